// File: rtl/pwm_fader_pkg.sv
// Shared definitions for the PWM fader and other consumers of the ramp
// counter.
//   fader_state_t : FSM state encoding (ST_IDLE, ST_FADE)
//   RAMP_UP/DOWN  : counter direction constants used to configure wrap
//                   detection (1 = ramp increments, 0 = ramp decrements)
package pwm_fader_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FADE = 1'b1
    } fader_state_t;

    localparam bit RAMP_UP   = 1'b1;
    localparam bit RAMP_DOWN = 1'b0;

endpackage

// File: rtl/pwm_fader_if.sv
// Target request channel into the PWM fader.
//   target       : requested final duty (SIZE bits)
//   target_valid : requester has a target this cycle
//   target_ready : fader accepts a target this cycle
// Handshake: a transfer happens on a rising clk edge where target_valid and
// target_ready are both high. The requester holds target stable while
// target_valid is high; target_ready never depends on target_valid.
interface pwm_fader_if #(
    parameter int SIZE = 8
) ();

    logic [SIZE-1:0] target;
    logic            target_valid;
    logic            target_ready;

    modport master (
        output target,
        output target_valid,
        input  target_ready
    );

    modport slave (
        input  target,
        input  target_valid,
        output target_ready
    );

endinterface

// File: rtl/ramp_wrap_detect.sv
// Detects the period boundary of a sawtooth counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   ramp       : current counter value
//   wrap       : combinational, high in the cycle the counter has wrapped
// A held value (prescaled counter) is never a wrap; the first sample after
// reset has no predecessor and is never a wrap either.
module ramp_wrap_detect
    import pwm_fader_pkg::*;
#(
    parameter int SIZE = 8,
    parameter bit UP   = RAMP_UP
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] ramp,
    output logic            wrap
);

    logic [SIZE-1:0] ramp_q;
    logic            prev_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramp_q  <= '0;
            prev_ok <= 1'b0;
        end else begin
            ramp_q  <= ramp;
            prev_ok <= 1'b1;
        end
    end

    // Strict comparison: equal consecutive values are a hold, not a wrap.
    assign wrap = prev_ok && (UP ? (ramp < ramp_q) : (ramp > ramp_q));

endmodule

// File: rtl/pwm_fader.sv
// PWM generator whose duty fades toward a requested target by STEP once per
// PWM period. Duty only changes at a detected counter wrap, so every period
// runs to completion with a single duty value.
//   clk, rst_n   : clock, asynchronous active-low reset
//   ramp         : sawtooth value from the upstream counter
//   tgt_if       : target request channel (slave side)
//   pwm          : registered PWM output, lags ramp by one cycle
//   duty         : currently applied duty
//   period_start : one-cycle pulse aligned with the first pwm of a period
//   done         : one-cycle pulse when duty reaches the target
//   state        : FSM state, exported for observation
module pwm_fader
    import pwm_fader_pkg::*;
#(
    parameter int SIZE = 8,
    parameter bit UP   = RAMP_UP,
    parameter int STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] ramp,
    pwm_fader_if.slave      tgt_if,
    output logic            pwm,
    output logic [SIZE-1:0] duty,
    output logic            period_start,
    output logic            done,
    output fader_state_t    state
);

    localparam logic [SIZE-1:0] STEP_N = SIZE'(STEP);
    localparam logic [SIZE:0]   STEP_W = (SIZE + 1)'(STEP);

    logic            wrap;
    logic            xfer;
    logic            tgt_above;
    logic [SIZE-1:0] tgt_q;
    logic [SIZE:0]   diff;

    ramp_wrap_detect #(
        .SIZE (SIZE),
        .UP   (UP)
    ) u_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .ramp  (ramp),
        .wrap  (wrap)
    );

    // Ready stays low through the done cycle so a new request is taken only
    // once the completed fade has been reported.
    assign tgt_if.target_ready = (state == ST_IDLE) && !done;
    assign xfer                = tgt_if.target_valid && tgt_if.target_ready;

    // Distance to target in SIZE+1 bits; when it exceeds STEP, moving by
    // STEP cannot overshoot the target or leave the 0..2^SIZE-1 range.
    assign tgt_above = tgt_q > duty;
    assign diff      = tgt_above ? ({1'b0, tgt_q} - {1'b0, duty})
                                 : ({1'b0, duty} - {1'b0, tgt_q});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            duty         <= '0;
            tgt_q        <= '0;
            pwm          <= 1'b0;
            period_start <= 1'b0;
            done         <= 1'b0;
        end else begin
            // Compare uses the duty held before any update at this edge.
            pwm          <= (ramp < duty);
            period_start <= wrap;
            done         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A wrap coinciding with the transfer does not move duty;
                    // the fade begins at the next wrap.
                    if (xfer) begin
                        tgt_q <= tgt_if.target;
                        if (tgt_if.target != duty) begin
                            state <= ST_FADE;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_FADE: begin
                    if (wrap) begin
                        if (diff <= STEP_W) begin
                            duty  <= tgt_q;
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else if (tgt_above) begin
                            duty <= duty + STEP_N;
                        end else begin
                            duty <= duty - STEP_N;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_fader.sv
// Bench for pwm_fader: an ascending-ramp instance (STEP=16) and a
// descending-ramp instance (STEP=50) run side by side against a rule-level
// model, with literal checks on the fade sequences and boundary cases.
module tb_pwm_fader;
    import pwm_fader_pkg::*;

    localparam int SIZE = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- DUTs ----------------
    logic [7:0]   ramp_a, ramp_b, duty_a, duty_b;
    logic         pwm_a, pwm_b, ps_a, ps_b, done_a, done_b;
    fader_state_t st_a, st_b;

    pwm_fader_if #(.SIZE(SIZE)) if_a ();
    pwm_fader_if #(.SIZE(SIZE)) if_b ();

    pwm_fader #(.SIZE(SIZE), .UP(1'b1), .STEP(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .ramp(ramp_a), .tgt_if(if_a),
        .pwm(pwm_a), .duty(duty_a), .period_start(ps_a), .done(done_a), .state(st_a)
    );

    pwm_fader #(.SIZE(SIZE), .UP(1'b0), .STEP(50)) dut_b (
        .clk(clk), .rst_n(rst_n), .ramp(ramp_b), .tgt_if(if_b),
        .pwm(pwm_b), .duty(duty_b), .period_start(ps_b), .done(done_b), .state(st_b)
    );

    // ---------------- bookkeeping ----------------
    int n_vec = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // Index 0: ascending ramp, STEP 16. Index 1: descending ramp, STEP 50.
    logic [7:0] m_duty[2], m_tgt[2], m_prev[2];
    bit         m_have_prev[2], m_fading[2];
    logic       nx_pwm[2], nx_ps[2], nx_done[2], nx_ready[2], nx_fade[2];
    logic [7:0] nx_duty[2];
    logic       exp_pwm[2], exp_ps[2], exp_done[2], exp_ready[2], exp_fade[2];
    logic [7:0] exp_duty[2];

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_duty[i] = 8'd0; m_tgt[i] = 8'd0; m_prev[i] = 8'd0;
            m_have_prev[i] = 1'b0; m_fading[i] = 1'b0;
            exp_pwm[i] = 1'b0; exp_ps[i] = 1'b0; exp_done[i] = 1'b0;
            exp_duty[i] = 8'd0; exp_fade[i] = 1'b0; exp_ready[i] = 1'b1;
        end
    endfunction

    // One clock of the fader rules; returns whether a target was accepted.
    function automatic bit model_step(input int i, input logic [7:0] r, input logic tv, input logic [7:0] tg);
        bit wrap, acc;
        int gap, stp;
        stp  = (i == 0) ? 16 : 50;
        wrap = m_have_prev[i] && ((i == 0) ? (r < m_prev[i]) : (r > m_prev[i]));
        acc  = tv && exp_ready[i];
        nx_pwm[i]  = (r < m_duty[i]);
        nx_ps[i]   = wrap;
        nx_done[i] = 1'b0;
        if (!m_fading[i]) begin
            if (acc) begin
                m_tgt[i] = tg;
                if (tg == m_duty[i]) nx_done[i] = 1'b1;
                else m_fading[i] = 1'b1;
            end
        end else if (wrap) begin
            gap = int'(m_tgt[i]) - int'(m_duty[i]);
            if (gap < 0) gap = -gap;
            if (gap <= stp) begin
                m_duty[i] = m_tgt[i];
                nx_done[i] = 1'b1;
                m_fading[i] = 1'b0;
            end else if (m_tgt[i] > m_duty[i]) begin
                m_duty[i] = 8'(int'(m_duty[i]) + stp);
            end else begin
                m_duty[i] = 8'(int'(m_duty[i]) - stp);
            end
        end
        m_prev[i] = r;
        m_have_prev[i] = 1'b1;
        nx_duty[i]  = m_duty[i];
        nx_fade[i]  = m_fading[i];
        nx_ready[i] = !m_fading[i] && !nx_done[i];
        return acc;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (check_en) begin
            check("pwm_a",   pwm_a,              exp_pwm[0]);
            check("duty_a",  duty_a,             exp_duty[0]);
            check("ps_a",    ps_a,               exp_ps[0]);
            check("done_a",  done_a,             exp_done[0]);
            check("ready_a", if_a.target_ready,  exp_ready[0]);
            check("state_a", st_a,               exp_fade[0] ? ST_FADE : ST_IDLE);
            check("pwm_b",   pwm_b,              exp_pwm[1]);
            check("duty_b",  duty_b,             exp_duty[1]);
            check("ps_b",    ps_b,               exp_ps[1]);
            check("done_b",  done_b,             exp_done[1]);
            check("ready_b", if_b.target_ready,  exp_ready[1]);
            check("state_b", st_b,               exp_fade[1] ? ST_FADE : ST_IDLE);
        end
    end

    // ---------------- driver ----------------
    logic [7:0] ra, rb, tg_a, tg_b;
    logic       tv_a, tv_b;
    int         ra_hold, ra_sub;
    logic [7:0] b_q[$];           // pending targets for instance B
    logic [7:0] chg_a[$], chg_b[$];
    logic [7:0] last_a, last_b;
    logic [7:0] exp_q[$];
    int         ps_cnt_a, high_cnt_a, rdy_low_a;

    task automatic tick();
        bit acc_b;
        @(negedge clk);
        tv_b = (b_q.size() > 0);
        tg_b = tv_b ? b_q[0] : 8'd0;
        ramp_a = ra; ramp_b = rb;
        if_a.target_valid = tv_a; if_a.target = tg_a;
        if_b.target_valid = tv_b; if_b.target = tg_b;
        void'(model_step(0, ra, tv_a, tg_a));
        acc_b = model_step(1, rb, tv_b, tg_b);
        if (acc_b) void'(b_q.pop_front());
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_pwm[i] = nx_pwm[i]; exp_ps[i] = nx_ps[i]; exp_done[i] = nx_done[i];
            exp_duty[i] = nx_duty[i]; exp_ready[i] = nx_ready[i]; exp_fade[i] = nx_fade[i];
        end
        ps_cnt_a   += int'(ps_a);
        high_cnt_a += int'(pwm_a);
        if (!if_a.target_ready) rdy_low_a++;
        if (duty_a != last_a) begin chg_a.push_back(duty_a); last_a = duty_a; end
        if (duty_b != last_b) begin chg_b.push_back(duty_b); last_b = duty_b; end
        ra_sub++;
        if (ra_sub >= ra_hold) begin ra_sub = 0; ra = ra + 8'd1; end
        rb = rb - 8'd1;
    endtask

    // Called just after a tick (posedge+1); asserts reset mid-cycle.
    task automatic assert_reset();
        #1;
        check_en = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        last_a = 8'd0; last_b = 8'd0;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        check_en = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst_n = 1'b0;
        tv_a = 1'b0; tg_a = 8'd0; tv_b = 1'b0; tg_b = 8'd0;
        if_a.target_valid = 1'b0; if_a.target = 8'd0;
        if_b.target_valid = 1'b0; if_b.target = 8'd0;
        ra = 8'd0; rb = 8'hFF; ramp_a = 8'd0; ramp_b = 8'hFF;
        ra_hold = 1; ra_sub = 0;
        last_a = 8'd0; last_b = 8'd0;
        ps_cnt_a = 0; high_cnt_a = 0; rdy_low_a = 0;
        model_reset();
        b_q = '{8'd200, 8'd20};
        release_reset();

        // Reset then idle: two wraps in 513 cycles of a 0..255 ramp.
        check("reset_ready_a", if_a.target_ready, 1);
        check("reset_duty_a", duty_a, 0);
        repeat (513) tick();
        check("idle_period_starts", ps_cnt_a, 2);
        check("idle_pwm_high", high_cnt_a, 0);
        check("idle_duty", duty_a, 0);

        // Fade up 0 -> 100 by 16.
        chg_a.delete();
        rdy_low_a = 0;
        tv_a = 1'b1; tg_a = 8'd100;
        tick();
        tv_a = 1'b0;
        n = 0;
        while (!done_a && n < 3000) begin tick(); n++; end
        check("fade_up_done_seen", done_a, 1);
        check("fade_up_final", duty_a, 100);
        check("fade_up_ready_low", rdy_low_a, 7 * 256);
        exp_q = '{8'd16, 8'd32, 8'd48, 8'd64, 8'd80, 8'd96, 8'd100};
        check("fade_up_count", chg_a.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < chg_a.size(); i++)
            check($sformatf("fade_up_step%0d", i), chg_a[i], exp_q[i]);
        high_cnt_a = 0;
        repeat (256) tick();
        check("settled_pwm_high", high_cnt_a, 100);

        // Target equal to duty: done next cycle, no fade.
        tv_a = 1'b1; tg_a = 8'd100;
        tick();
        tv_a = 1'b0;
        check("same_target_done", done_a, 1);
        check("same_target_state", st_a, ST_IDLE);
        check("same_target_ready", if_a.target_ready, 0);
        tick();
        check("same_target_done_clear", done_a, 0);
        check("same_target_ready_back", if_a.target_ready, 1);

        // Transfer in the wrap cycle; requests while busy are ignored.
        n = 0;
        while (ra != 8'd0 && n < 300) begin tick(); n++; end
        tv_a = 1'b1; tg_a = 8'd150;
        tick();
        check("wrap_xfer_ps", ps_a, 1);
        check("wrap_xfer_duty", duty_a, 100);
        check("wrap_xfer_state", st_a, ST_FADE);
        tg_a = 8'd0;
        repeat (255) tick();
        check("busy_ready", if_a.target_ready, 0);
        check("busy_duty_hold", duty_a, 100);
        tv_a = 1'b0;
        tick();
        check("wrap_xfer_first_step", duty_a, 116);
        n = 0;
        while (!done_a && n < 1200) begin tick(); n++; end
        check("wrap_xfer_final", duty_a, 150);

        // Prescaled ramp: each value held 4 cycles, 2048 cycles = 2 sweeps.
        n = 0;
        while (ra != 8'd1 && n < 300) begin tick(); n++; end
        ra_hold = 4; ra_sub = 0; ps_cnt_a = 0;
        repeat (2048) tick();
        check("prescaled_period_starts", ps_cnt_a, 2);
        ra_hold = 1; ra_sub = 0;

        // Descending instance: 0 -> 200 -> 20 by 50.
        exp_q = '{8'd50, 8'd100, 8'd150, 8'd200, 8'd150, 8'd100, 8'd50, 8'd20};
        check("fade_down_count", chg_b.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < chg_b.size(); i++)
            check($sformatf("fade_down_step%0d", i), chg_b[i], exp_q[i]);

        // Reset mid-fade at duty 64.
        assert_reset();
        ra = 8'd0; rb = 8'hFF;
        release_reset();
        tv_a = 1'b1; tg_a = 8'd200;
        tick();
        tv_a = 1'b0;
        n = 0;
        while (duty_a != 8'd64 && n < 1500) begin tick(); n++; end
        check("mid_fade_reach64", duty_a, 64);
        repeat (10) tick();
        check("mid_fade_pwm_high", pwm_a, 1);
        assert_reset();
        check("mid_reset_pwm", pwm_a, 0);
        check("mid_reset_duty", duty_a, 0);
        check("mid_reset_done", done_a, 0);
        check("mid_reset_state", st_a, ST_IDLE);
        release_reset();
        tick();
        check("post_reset_no_ps", ps_a, 0);
        check("post_reset_ready", if_a.target_ready, 1);
        check("post_reset_duty", duty_a, 0);
        repeat (300) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
